// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Main control FSM for the 64-bit multi-cycle RISC-V core (ld, sd, add/sub/and/or, beq).
// It sequences fetch/decode/execute/memory/writeback and drives the datapath enables
// and ctrl_ALU_op (00 add, 01 branch subtract, 10 R-type funct decode) for ALU_control.
// It also counts retired instructions and traps illegal opcodes and memory timeouts.
//
// Optional build macro CTRL_ADDI_EN: when defined, addi (opcode 0010011, funct3 000)
// is legal and runs DECODE -> EXEC_I -> WB_ALU. When it is not defined, that opcode
// traps as illegal.
//
// Handshake: a memory access in FETCH, MEM_RD or MEM_WR holds its request high and
// completes in the first cycle mem_ready is high. There is no separate valid signal;
// the request strobes act as valid and mem_ready acts as ready. If mem_ready stays low
// for MEM_TIMEOUT cycles in one access, the FSM halts with bus_error set. A value of 0
// disables the timeout.
//
// state_dbg shows the current FSM state encoding so that checkers can observe it.
module multicycle_main_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [1:0]          ctrl_ALU_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                halted,
  output logic                illegal_instr,
  output logic                bus_error,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_WB_MEM   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10,
    S_EXEC_I   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef CTRL_ADDI_EN
  localparam logic [6:0] OP_ADDI = 7'b0010011;
`endif

  // The timeout counter only needs to reach MEM_TIMEOUT-1. It keeps at least one bit
  // so that a disabled timeout still has a legal width.
  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

  state_t            state;
  state_t            state_next;
  state_t            decode_next;
  logic [6:0]        op_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              mem_wait;
  logic              timeout_hit;
  logic              retire_now;
  logic              set_illegal;

  // A memory access is outstanding in these states.
  assign mem_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // The last allowed wait cycle with mem_ready still low. If mem_ready is high in that
  // same cycle, the access completes.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready && (tmo_cnt == TMO_LAST);

  // An instruction retires in the cycle its final state hands over to FETCH.
  assign retire_now = (state == S_WB_MEM) || (state == S_WB_ALU) || (state == S_BRANCH) ||
                      ((state == S_MEM_WR) && mem_ready);

  assign set_illegal = (state == S_DECODE) && (decode_next == S_HALT);

  assign state_dbg = state;

  // Opcode/funct3 legality check and dispatch target for the DECODE state.
  always_comb begin
    decode_next = S_HALT;
    case (opcode)
      OP_LD:   if (funct3 == 3'b011) decode_next = S_MEM_ADDR;
      OP_SD:   if (funct3 == 3'b011) decode_next = S_MEM_ADDR;
      OP_R:    decode_next = S_EXEC_R;
      OP_BEQ:  if (funct3 == 3'b000) decode_next = S_BRANCH;
`ifdef CTRL_ADDI_EN
      OP_ADDI: if (funct3 == 3'b000) decode_next = S_EXEC_I;
`endif
      default: decode_next = S_HALT;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_next = S_DECODE;
        else if (timeout_hit) state_next = S_HALT;
      end
      S_DECODE:   state_next = decode_next;
      // After DECODE the opcode input may already belong to the next instruction,
      // so the choice between load and store uses the latched copy.
      S_MEM_ADDR: state_next = (op_q == OP_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)        state_next = S_WB_MEM;
        else if (timeout_hit) state_next = S_HALT;
      end
      S_MEM_WR: begin
        if (mem_ready)        state_next = S_FETCH;
        else if (timeout_hit) state_next = S_HALT;
      end
      S_WB_MEM:   state_next = S_FETCH;
      S_EXEC_R:   state_next = S_WB_ALU;
      S_EXEC_I:   state_next = S_WB_ALU;
      S_WB_ALU:   state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_HALT;
    endcase
  end

  // Control outputs are decoded from the state. The only signals that depend on
  // inputs are pc_write and ir_write, which follow mem_ready in FETCH, and pc_write,
  // which follows zero in BRANCH.
  always_comb begin
    ctrl_ALU_op = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // The branch target old_pc + imm is parked in ALUOut.
        alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        ctrl_ALU_op = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        ctrl_ALU_op = 2'b01;
        pc_src      = 1'b1;
        pc_write    = zero;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  // State register. The asynchronous reset drops memory requests immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Latch the opcode in DECODE for use by the later states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_q <= '0;
    else if (state == S_DECODE)  op_q <= opcode;
  end

  // Wait-cycle counter. It clears on every state change, which covers entry into each
  // wait state, and counts the cycles with mem_ready low while an access is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        tmo_cnt <= '0;
    else if (state_next != state)      tmo_cnt <= '0;
    else if (mem_wait && !mem_ready)   tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Retired-instruction counter, which wraps naturally, and the sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired       <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      if (retire_now)  retired       <= retired + 1'b1;
      if (set_illegal) illegal_instr <= 1'b1;
      if (timeout_hit) bus_error     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control
// Directed bench for multicycle_main_control, built with MEM_TIMEOUT = 4 and
// RETIRE_W = 4 so that the timeout boundary and counter wrap are short to reach.
// When CTRL_ADDI_EN is defined, the addi vector expects the EXEC_I path.
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ctrl_ALU_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src;
  logic       reg_write, mem_to_reg, halted, illegal_instr, bus_error;
  logic [3:0] retired;
  logic [3:0] state_dbg;
  logic [13:0] ctl;

  int total = 0;
  int bad   = 0;

  // Packed control word: {alu_op[1:0], src_a, src_b[1:0], rd, wr, i_or_d, ir_w, pc_w, pc_src, reg_w, mem_to_reg, halted}
  localparam logic [13:0] W_IDLE     = 14'b00_0_00_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] W_FETCH    = 14'b00_0_01_1_0_0_1_1_0_0_0_0;
  localparam logic [13:0] W_FETCH_WT = 14'b00_0_01_1_0_0_0_0_0_0_0_0;
  localparam logic [13:0] W_DECODE   = 14'b00_0_10_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] W_MEMADDR  = 14'b00_1_10_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] W_MEMRD    = 14'b00_0_00_1_0_1_0_0_0_0_0_0;
  localparam logic [13:0] W_MEMWR    = 14'b00_0_00_0_1_1_0_0_0_0_0_0;
  localparam logic [13:0] W_WBMEM    = 14'b00_0_00_0_0_0_0_0_0_1_1_0;
  localparam logic [13:0] W_EXECR    = 14'b10_1_00_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] W_WBALU    = 14'b00_0_00_0_0_0_0_0_0_1_0_0;
  localparam logic [13:0] W_BR_T     = 14'b01_1_00_0_0_0_0_1_1_0_0_0;
  localparam logic [13:0] W_BR_N     = 14'b01_1_00_0_0_0_0_0_1_0_0_0;
  localparam logic [13:0] W_HALT     = 14'b00_0_00_0_0_0_0_0_0_0_0_1;
`ifdef CTRL_ADDI_EN
  localparam logic [13:0] W_EXECI    = 14'b00_1_10_0_0_0_0_0_0_0_0_0;
`endif

  assign ctl = {ctrl_ALU_op, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
                ir_write, pc_write, pc_src, reg_write, mem_to_reg, halted};

  multicycle_main_control #(.MEM_TIMEOUT(4), .RETIRE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .ctrl_ALU_op(ctrl_ALU_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .retired(retired),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // read and write strobes must never be high together
  always @(negedge clk)
    if (rst_n && mem_read && mem_write) check("rd_wr_excl", 32'd1, 32'd0);

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  // reset, then walk IDLE -> FETCH; ends at FETCH with mem_ready high
  task automatic start();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct3 = '0;
    #3;
    check("rst_ctl", 32'(ctl), 32'(W_IDLE));
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_flags", {30'd0, illegal_instr, bus_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle", 32'(ctl), 32'(W_IDLE));
    cyc();
    check("fetch", 32'(ctl), 32'(W_FETCH));
  endtask

  // one R-type instruction from FETCH back to FETCH (4 cycles)
  task automatic run_r();
    set_instr(7'b0110011, 3'b000);
    cyc(); check("r_decode", 32'(ctl), 32'(W_DECODE));
    cyc(); check("r_exec", 32'(ctl), 32'(W_EXECR));
    cyc(); check("r_wb", 32'(ctl), 32'(W_WBALU));
    cyc(); check("r_fetch", 32'(ctl), 32'(W_FETCH));
  endtask

  // main stimulus: directed vectors, each expected value written out by hand
  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct3 = '0;

    // R-type, then ld with three wait cycles, then beq taken and not taken, then sd
    start();
    run_r();
    check("r_retired", 32'(retired), 32'd1);

    set_instr(7'b0000011, 3'b011);
    cyc(); check("ld_decode", 32'(ctl), 32'(W_DECODE));
    cyc(); check("ld_memaddr", 32'(ctl), 32'(W_MEMADDR));
    opcode = 7'b1111111;  // the MEM_RD/MEM_WR choice must use the latched opcode
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); check("ld_memrd", 32'(ctl), 32'(W_MEMRD));
      if (i == 3) mem_ready = 1'b1;
    end
    cyc(); check("ld_wbmem", 32'(ctl), 32'(W_WBMEM));
    cyc(); check("ld_fetch", 32'(ctl), 32'(W_FETCH));
    check("ld_retired", 32'(retired), 32'd2);
    check("ld_no_buserr", 32'(bus_error), 32'd0);

    set_instr(7'b1100011, 3'b000); zero = 1'b1;
    cyc(); check("beq_t_decode", 32'(ctl), 32'(W_DECODE));
    cyc(); check("beq_t_branch", 32'(ctl), 32'(W_BR_T));
    cyc(); check("beq_t_retired", 32'(retired), 32'd3);
    zero = 1'b0;
    cyc(); check("beq_n_decode", 32'(ctl), 32'(W_DECODE));
    cyc(); check("beq_n_branch", 32'(ctl), 32'(W_BR_N));
    cyc(); check("beq_n_fetch", 32'(ctl), 32'(W_FETCH));
    check("beq_n_retired", 32'(retired), 32'd4);

    set_instr(7'b0100011, 3'b011);
    cyc(); check("sd_decode", 32'(ctl), 32'(W_DECODE));
    cyc(); check("sd_memaddr", 32'(ctl), 32'(W_MEMADDR));
    cyc(); check("sd_memwr", 32'(ctl), 32'(W_MEMWR));
    cyc(); check("sd_fetch", 32'(ctl), 32'(W_FETCH));
    check("sd_retired", 32'(retired), 32'd5);

    // sd with mem_ready arriving in the 4th MEM_WR cycle: no error
    cyc(); cyc(); mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); check("sd4_memwr", 32'(ctl), 32'(W_MEMWR));
      if (i == 3) mem_ready = 1'b1;
    end
    cyc(); check("sd4_fetch", 32'(ctl), 32'(W_FETCH));
    check("sd4_buserr", 32'(bus_error), 32'd0);
    check("sd4_retired", 32'(retired), 32'd6);

    // sd with mem_ready held low: HALT with bus_error after 4 MEM_WR cycles
    cyc(); cyc(); mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); check("sdto_memwr", 32'(ctl), 32'(W_MEMWR));
    end
    cyc(); check("sdto_halt", 32'(ctl), 32'(W_HALT));
    check("sdto_buserr", 32'(bus_error), 32'd1);
    check("sdto_illegal", 32'(illegal_instr), 32'd0);
    check("sdto_retired", 32'(retired), 32'd6);

    // reset during a MEM_RD wait
    start();
    run_r();
    set_instr(7'b0000011, 3'b011);
    cyc(); cyc(); mem_ready = 1'b0;
    cyc(); check("rstmid_memrd", 32'(ctl), 32'(W_MEMRD));
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_memread", 32'(mem_read), 32'd0);
    check("rstmid_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    check("rstmid_idle", 32'(ctl), 32'(W_IDLE));
    cyc(); check("rstmid_fetch", 32'(ctl), 32'(W_FETCH));

    // FETCH wait, then illegal opcode 1111111 held in HALT for 20 cycles
    mem_ready = 1'b0;
    #1 check("fetch_wait", 32'(ctl), 32'(W_FETCH_WT));
    cyc(); check("fetch_stay", 32'(ctl), 32'(W_FETCH_WT));
    mem_ready = 1'b1;
    set_instr(7'b1111111, 3'b000);
    cyc(); check("ill_decode", 32'(ctl), 32'(W_DECODE));
    cyc();
    check("ill_flag", 32'(illegal_instr), 32'd1);
    check("ill_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; zero = i[1];
      cyc(); check("ill_hold", 32'(ctl), 32'(W_HALT));
    end

    // ld with funct3 = 010 is illegal
    start();
    set_instr(7'b0000011, 3'b010);
    cyc(); cyc();
    check("ldf3_halt", 32'(ctl), 32'(W_HALT));
    check("ldf3_illegal", 32'(illegal_instr), 32'd1);

    // addi: legal only with CTRL_ADDI_EN
    start();
    set_instr(7'b0010011, 3'b000);
    cyc(); check("addi_decode", 32'(ctl), 32'(W_DECODE));
`ifdef CTRL_ADDI_EN
    cyc(); check("addi_exec", 32'(ctl), 32'(W_EXECI));
    cyc(); check("addi_wb", 32'(ctl), 32'(W_WBALU));
    cyc(); check("addi_fetch", 32'(ctl), 32'(W_FETCH));
    check("addi_retired", 32'(retired), 32'd1);
`else
    cyc(); check("addi_halt", 32'(ctl), 32'(W_HALT));
    check("addi_illegal", 32'(illegal_instr), 32'd1);
`endif

    // retired counter wraps at 2^4
    start();
    for (int i = 0; i < 15; i++) run_r();
    check("wrap_15", 32'(retired), 32'd15);
    run_r();
    check("wrap_0", 32'(retired), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
